// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: configuration string
// constants, the clear/run state type and the address-width helper.
package mem_pkg;

    localparam string PERF_HIGH       = "HIGH_PERFORMANCE";
    localparam string PERF_LOW        = "LOW_LATENCY";
    localparam string RDW_WRITE_FIRST = "WRITE_FIRST";
    localparam string RDW_READ_FIRST  = "READ_FIRST";

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_e;

    // Bits needed to hold the value 'depth'; never returns less than 1.
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        for (r = 0; d > 0; r++) begin
            d = d >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Post-reset zero-fill sequencer: walks every entry once in CLEAR, then
// parks in RUN and raises READY so the user ports are accepted.
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int RAM_DEPTH      = 512,
    parameter int AW             = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_clear_we,
    output logic [AW-1:0] o_clear_addr,
    output logic          o_ready
);

    localparam clr_state_e    RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    clr_state_e    r_state;
    clr_state_e    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_ready;

    // State, counter and READY registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RST_STATE;
            r_cnt   <= {AW{1'b0}};
            r_ready <= (CLEAR_ON_RESET == 0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    // Next-state logic: leave CLEAR right after the last entry is written.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = {AW{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_cnt_nxt   = {AW{1'b0}};
            end
        endcase
    end

    assign o_clear_we   = (r_state == ST_CLEAR);
    assign o_clear_addr = r_cnt;
    assign o_ready      = r_ready;

endmodule

// File: rtl/mem_dual_port_be.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write
// behaviour, 1- or 2-cycle read pipeline with matching valid, and zero-clear.
module mem_dual_port_be
    import mem_pkg::*;
#(
    parameter int    RAM_WIDTH       = 64,
    parameter int    BYTE_WIDTH      = 8,
    parameter int    RAM_DEPTH       = 512,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string RDW_MODE        = "WRITE_FIRST",
    parameter int    CLEAR_ON_RESET  = 1,
    localparam int   AW              = clogb2(RAM_DEPTH - 1),
    localparam int   NB              = RAM_WIDTH / BYTE_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [AW-1:0]        ADDR_W,
    input  logic [AW-1:0]        ADDR_R,
    input  logic [RAM_WIDTH-1:0] DATA_IN,
    input  logic                 WR_ENB,
    input  logic [NB-1:0]        BYTE_ENB,
    input  logic                 RD_ENB,
    input  logic                 OUT_RST,
    input  logic                 OUT_ENB,
    output logic [RAM_WIDTH-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 READY
);

    localparam bit IS_HP     = (RAM_PERFORMANCE != PERF_LOW);
    localparam bit IS_WF     = (RDW_MODE != RDW_READ_FIRST);
    localparam bit CFG_LEGAL = ((RAM_PERFORMANCE == PERF_HIGH) || (RAM_PERFORMANCE == PERF_LOW))
                            && ((RDW_MODE == RDW_WRITE_FIRST) || (RDW_MODE == RDW_READ_FIRST))
                            && ((RAM_WIDTH % BYTE_WIDTH) == 0);

    if (!CFG_LEGAL) begin : g_bad_cfg
        $error("mem_dual_port_be: illegal RAM_PERFORMANCE/RDW_MODE/width combination");
    end

    logic                 w_clear_we;
    logic [AW-1:0]        w_clear_addr;
    logic                 w_ready;
    logic                 w_run;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_usr_we;
    logic                 w_usr_rd;
    logic                 w_rdw_hit;
    logic [AW-1:0]        w_mem_addr;
    logic [RAM_WIDTH-1:0] w_ram_data;
    logic                 r_valid1;

    mem_clear_ctrl #(
        .RAM_DEPTH      (RAM_DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .i_clk        (CLK),
        .i_rst        (RST),
        .o_clear_we   (w_clear_we),
        .o_clear_addr (w_clear_addr),
        .o_ready      (w_ready)
    );

    // Out-of-range addresses only exist when RAM_DEPTH is not a power of 2.
    assign w_wr_ok    = (32'(ADDR_W) < 32'(RAM_DEPTH));
    assign w_rd_ok    = (32'(ADDR_R) < 32'(RAM_DEPTH));
    assign w_run      = w_ready & ~RST;
    assign w_usr_we   = w_run & WR_ENB & w_wr_ok;
    assign w_usr_rd   = w_run & RD_ENB;
    assign w_rdw_hit  = w_usr_we & w_usr_rd & (ADDR_W == ADDR_R);
    assign w_mem_addr = w_clear_we ? w_clear_addr : ADDR_W;

    // Each lane is its own narrow array so a partial store touches only its lanes.
    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [BYTE_WIDTH-1:0] r_mem [RAM_DEPTH];
        logic [BYTE_WIDTH-1:0] r_rd;
        logic [BYTE_WIDTH-1:0] w_din;
        logic                  w_lane_we;

        assign w_din     = w_clear_we ? {BYTE_WIDTH{1'b0}} : DATA_IN[b*BYTE_WIDTH +: BYTE_WIDTH];
        assign w_lane_we = w_clear_we | (w_usr_we & BYTE_ENB[b]);

        // Lane storage write (zero-fill or user store).
        always_ff @(posedge CLK) begin
            if (w_lane_we) begin
                r_mem[w_mem_addr] <= w_din;
            end
        end

        // Read stage 1: bypass fresh lane data on a WRITE_FIRST collision.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_rd <= {BYTE_WIDTH{1'b0}};
            end else if (w_usr_rd) begin
                if (!w_rd_ok) begin
                    r_rd <= {BYTE_WIDTH{1'b0}};
                end else if (IS_WF && w_rdw_hit && BYTE_ENB[b]) begin
                    r_rd <= DATA_IN[b*BYTE_WIDTH +: BYTE_WIDTH];
                end else begin
                    r_rd <= r_mem[ADDR_R];
                end
            end
        end

        assign w_ram_data[b*BYTE_WIDTH +: BYTE_WIDTH] = r_rd;
    end

    // Stage-1 valid tracks accepted reads only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= w_usr_rd;
        end
    end

    if (IS_HP) begin : g_out_reg
        logic [RAM_WIDTH-1:0] r_dout;
        logic                 r_dvalid;

        // Output register: OUT_RST wins over OUT_ENB, otherwise hold.
        always_ff @(posedge CLK) begin
            if (RST || OUT_RST) begin
                r_dout   <= {RAM_WIDTH{1'b0}};
                r_dvalid <= 1'b0;
            end else if (OUT_ENB) begin
                r_dout   <= w_ram_data;
                r_dvalid <= r_valid1;
            end
        end

        assign DATA_OUT   = r_dout;
        assign DATA_VALID = r_dvalid;
    end else begin : g_out_direct
        logic w_unused_out_ctl;

        assign w_unused_out_ctl = OUT_RST | OUT_ENB;
        assign DATA_OUT         = w_ram_data;
        assign DATA_VALID       = r_valid1;
    end

    assign READY = w_ready;

endmodule
